// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// key_pkg : shared constants and state encoding for the key conditioner
// Rev 1.0
// ============================================================================
package key_pkg;

    localparam logic [1:0] ST_REL        = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
    localparam logic [1:0] ST_PRESSED    = 2'd2;
    localparam logic [1:0] ST_REL_WAIT   = 2'd3;

    typedef enum logic [1:0] {
        KS_REL        = ST_REL,
        KS_PRESS_WAIT = ST_PRESS_WAIT,
        KS_PRESSED    = ST_PRESSED,
        KS_REL_WAIT   = ST_REL_WAIT
    } key_state_e;

    localparam int unsigned DEF_DEB_CYCLES  = 1000000;
    localparam int unsigned DEF_LONG_CYCLES = 50000000;
    localparam int unsigned SYNC_DEPTH      = 2;

endpackage
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
// key_debounce_ch : one key channel - synchroniser, debounce FSM, hold timer
// Rev 1.0
// ============================================================================
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic held_o
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0] C_DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] C_LONG     = HW'(LONG_CYCLES);

    logic [SYNC_DEPTH-1:0] sync_q;
    key_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic                  level_q, level_d;
    logic                  press_q, press_d;
    logic                  release_q, release_d;
    logic                  long_q, long_d;
    logic                  held_q, held_d;
    logic                  w_s;
    logic [HW-1:0]         w_hold_inc;

    // Flops hold the raw active-low pad, so reset value 1 means released
    assign w_s        = ~sync_q[SYNC_DEPTH-1];
    assign w_hold_inc = (hold_q == C_LONG) ? hold_q : hold_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '1;
            state_q   <= KS_REL;
            cnt_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_DEPTH-2:0], key_n_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= held_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        level_d   = level_q;
        held_d    = held_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        case (state_q)
            KS_REL: begin
                if (w_s) begin
                    state_d = KS_PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            KS_PRESS_WAIT: begin
                if (!w_s) begin
                    state_d = KS_REL;
                    cnt_d   = '0;
                end else if (cnt_q == C_DEB_LAST) begin
                    state_d = KS_PRESSED;
                    cnt_d   = '0;
                    hold_d  = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            KS_PRESSED: begin
                if (!w_s) begin
                    state_d = KS_REL_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            KS_REL_WAIT: begin
                if (w_s) begin
                    state_d = KS_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == C_DEB_LAST) begin
                    state_d   = KS_REL;
                    cnt_d     = '0;
                    hold_d    = '0;
                    level_d   = 1'b0;
                    held_d    = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = KS_REL;
        endcase

        // Hold timer runs across PRESSED/REL_WAIT; a release accepted on the
        // threshold cycle suppresses the long pulse.
        if (level_q && !release_d) begin
            hold_d = w_hold_inc;
            if ((w_hold_inc == C_LONG) && (hold_q != C_LONG)) begin
                long_d = 1'b1;
                held_d = 1'b1;
            end
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign held_o    = held_q;

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// key_conditioner : array of independent debounced pushbutton channels
// Rev 1.0
// ============================================================================
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 2,
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n_i,
    output logic [NUM_KEYS-1:0] key_level_o,
    output logic [NUM_KEYS-1:0] key_press_o,
    output logic [NUM_KEYS-1:0] key_release_o,
    output logic [NUM_KEYS-1:0] key_long_o,
    output logic [NUM_KEYS-1:0] key_held_o
);

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_debounce_ch #(
            .DEB_CYCLES  (DEB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .key_n_i   (key_n_i[gi]),
            .level_o   (key_level_o[gi]),
            .press_o   (key_press_o[gi]),
            .release_o (key_release_o[gi]),
            .long_o    (key_long_o[gi]),
            .held_o    (key_held_o[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
// tb_key_conditioner : directed + random pad stimulus against a run-length model
// Rev 1.0
// ============================================================================
module tb_key_conditioner;

    localparam int NK   = 2;
    localparam int DEB  = 4;
    localparam int LONG = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] w_level, w_press, w_release, w_long, w_held;

    key_conditioner #(
        .NUM_KEYS    (NK),
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_n_i       (key_n),
        .key_level_o   (w_level),
        .key_press_o   (w_press),
        .key_release_o (w_release),
        .key_long_o    (w_long),
        .key_held_o    (w_held)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: pad samples delayed two edges, a level flips after DEB
    // consecutive disagreeing samples, hold age counts edges since press.
    logic [NK-1:0] m_lvl, m_prs, m_rls, m_lng, m_hld, h1, h2;
    int            run [NK];
    int            age [NK];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lvl = '0; m_prs = '0; m_rls = '0; m_lng = '0; m_hld = '0;
        h1 = '0; h2 = '0;
        for (int i = 0; i < NK; i++) begin
            run[i] = 0;
            age[i] = 0;
        end
    endtask

    task automatic model_step(input logic [NK-1:0] kn);
        logic s;
        for (int i = 0; i < NK; i++) begin
            s     = h2[i];
            h2[i] = h1[i];
            h1[i] = ~kn[i];
            m_prs[i] = 1'b0;
            m_rls[i] = 1'b0;
            m_lng[i] = 1'b0;
            run[i] = (s != m_lvl[i]) ? run[i] + 1 : 0;
            if (run[i] == DEB) begin
                run[i]   = 0;
                m_lvl[i] = ~m_lvl[i];
                age[i]   = 0;
                if (m_lvl[i]) m_prs[i] = 1'b1;
                else begin
                    m_rls[i] = 1'b1;
                    m_hld[i] = 1'b0;
                end
            end else if (m_lvl[i] && age[i] < LONG) begin
                age[i]++;
                if (age[i] == LONG) begin
                    m_lng[i] = 1'b1;
                    m_hld[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("level",   32'(w_level),   32'(m_lvl));
        chk("press",   32'(w_press),   32'(m_prs));
        chk("release", 32'(w_release), 32'(m_rls));
        chk("long",    32'(w_long),    32'(m_lng));
        chk("held",    32'(w_held),    32'(m_hld));
    endtask

    task automatic cycle(input logic [NK-1:0] kn);
        @(negedge clk);
        compare_all();
        key_n = kn;
        model_step(kn);
    endtask

    task automatic seg(input logic [NK-1:0] kn, input int n);
        for (int c = 0; c < n; c++) cycle(kn);
    endtask

    task automatic do_reset(input logic [NK-1:0] kn);
        @(negedge clk);
        compare_all();
        #2 rst = 1'b1;
        #1;
        chk("rst_level",   32'(w_level),   32'd0);
        chk("rst_press",   32'(w_press),   32'd0);
        chk("rst_release", 32'(w_release), 32'd0);
        chk("rst_long",    32'(w_long),    32'd0);
        chk("rst_held",    32'(w_held),    32'd0);
        model_reset();
        @(negedge clk);
        rst   = 1'b0;
        key_n = kn;
        model_step(kn);
    endtask

    logic [NK-1:0] r_kn;
    int            rem [NK];

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst   = 1'b0;
        key_n = '1;
        model_step('1);

        seg(2'b11, 5);
        // clean press with long hold, then release
        seg(2'b10, 30);  seg(2'b11, 10);
        // bounce shorter than the debounce window
        for (int b = 0; b < 3; b++) begin
            seg(2'b10, 2); seg(2'b11, 2);
        end
        seg(2'b11, 10);
        // release with a one-cycle bounce
        seg(2'b10, 30);
        seg(2'b11, 3); seg(2'b10, 1); seg(2'b11, 12);
        // short press
        seg(2'b10, 10); seg(2'b11, 12);
        // release acceptance around the long threshold (collision at 20)
        seg(2'b10, 19); seg(2'b11, 12);
        seg(2'b10, 20); seg(2'b11, 12);
        seg(2'b10, 21); seg(2'b11, 12);
        // key 1 held past long, reset mid-hold, re-detected as fresh press
        seg(2'b01, 30);
        do_reset(2'b01);
        seg(2'b01, 12); seg(2'b11, 10);
        // both keys together
        seg(2'b00, 25); seg(2'b10, 8); seg(2'b11, 10);

        r_kn = '1;
        for (int i = 0; i < NK; i++) rem[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NK; i++) begin
                if (rem[i] == 0) begin
                    r_kn[i] = 1'($urandom_range(0, 1));
                    rem[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 40))
                                                          : int'($urandom_range(1, 6));
                end
                rem[i]--;
            end
            if ($urandom_range(0, 399) == 0) do_reset(r_kn);
            else cycle(r_kn);
        end
        seg(2'b11, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
